// File: rtl/irrigation_pkg.sv
// Shared types and helpers for the irrigation zone scheduler.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    IRRIGATE,
    PAUSE,
    FAULT
  } state_t;

  // {min_tens, min_units, sec_tens}, each a BCD digit
  typedef logic [11:0] bcd_time_t;

  localparam bcd_time_t BCD_ZERO = 12'h000;
  localparam bcd_time_t BCD_ONE  = 12'h001;

  // Tank sensors are stacked: a higher mark can never read wet while a lower one reads dry.
  function automatic logic sensors_conflict(input logic low, input logic mid, input logic high);
    return (high & ~mid) | (mid & ~low);
  endfunction

endpackage

// File: rtl/irrigation_zone_scheduler_if.sv
// Zone-facing signal bundle: requests and abort in, valves and run status out.
interface irrigation_zone_scheduler_if #(
  parameter int ZONES = 4
);
  localparam int ZW = $clog2(ZONES);

  logic [ZONES-1:0] zone_request;
  logic             abort;
  logic [ZONES-1:0] sprinkler_valve;
  logic [ZONES-1:0] dripper_valve;
  logic [ZW-1:0]    active_zone;
  logic             busy;
  logic [11:0]      timer_bcd;

  modport master (
    output zone_request, abort,
    input  sprinkler_valve, dripper_valve, active_zone, busy, timer_bcd
  );

  modport slave (
    input  zone_request, abort,
    output sprinkler_valve, dripper_valve, active_zone, busy, timer_bcd
  );

endinterface

// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown (MM:S, 10 s units) with load, clear and tick-enable.
module bcd_countdown_timer
  import irrigation_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      clear,
  input  logic      load,
  input  bcd_time_t load_value,
  input  logic      tick,
  output bcd_time_t value,
  output logic      zero,
  output logic      last
);

  // Seconds digit only counts tens of seconds, so it borrows from 0 to 5.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    logic [3:0] mt, mu, st;
    {mt, mu, st} = t;
    if (t == BCD_ZERO) return t;
    if (st != 4'd0) begin
      st = st - 4'd1;
    end else begin
      st = 4'd5;
      if (mu != 4'd0) begin
        mu = mu - 4'd1;
      end else begin
        mu = 4'd9;
        mt = mt - 4'd1;
      end
    end
    return {mt, mu, st};
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= BCD_ZERO;
    end else if (clear) begin
      value <= BCD_ZERO;
    end else if (load) begin
      value <= load_value;
    end else if (tick) begin
      value <= bcd_dec(value);
    end
  end

  assign zero = (value == BCD_ZERO);
  assign last = (value == BCD_ONE);

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin multi-zone irrigation scheduler sharing one tank; FSM, arbiter, prescaler.
// Define CYCLE_COUNT_EN to add the saturating runs_done output.
module irrigation_zone_scheduler
  import irrigation_pkg::*;
#(
  parameter int        ZONES          = 4,
  parameter int        TICK_DIV       = 50000000,
  parameter bcd_time_t SPRINKLER_TIME = 12'h200,
  parameter bcd_time_t DRIPPER_TIME   = 12'h300
) (
  input  logic clock,
  input  logic reset_n,
  input  logic low_water_level,
  input  logic mid_water_level,
  input  logic high_water_level,
  input  logic air_humidity,
  input  logic low_temperature,
  irrigation_zone_scheduler_if.slave zif,
  output logic water_supply_valve,
  output logic alarm,
  output logic conflicting_values
`ifdef CYCLE_COUNT_EN
  ,
  output logic [7:0] runs_done
`endif
);

  localparam int ZW = $clog2(ZONES);
  localparam int PW = $clog2(TICK_DIV);

  state_t          state, state_nxt;
  logic [ZW-1:0]   ptr;
  logic [ZW-1:0]   pick;
  logic [ZW-1:0]   zone_nxt;
  logic [ZW-1:0]   ptr_inc;
  logic            found;
  int              idx;
  logic            sprinkler_mode;
  logic            sprinkler_sel;
  logic            mode_nxt;
  logic [PW-1:0]   presc;
  logic            tick;
  logic            conflict;
  logic            req_drop;
  logic            done;
  logic            run_end;
  logic            start_run;
  logic            timer_clear;
  bcd_time_t       timer_value;
  logic            timer_zero;
  logic            timer_last;
  logic [ZONES-1:0] zone_onehot;

  assign conflict      = sensors_conflict(low_water_level, mid_water_level, high_water_level);
  assign sprinkler_sel = mid_water_level & ~air_humidity & ~low_temperature;
  assign req_drop      = ~zif.zone_request[zif.active_zone];
  assign tick          = (state == IRRIGATE) && (presc == PW'(TICK_DIV - 1));
  assign done          = timer_zero | (tick & timer_last);
  assign ptr_inc       = ZW'((int'(zif.active_zone) + 1) % ZONES);
  assign start_run     = (state == SELECT) && (state_nxt == IRRIGATE);
  assign timer_clear   = (state_nxt == IDLE) || (state_nxt == FAULT);

  // First requesting zone at or after the pointer, wrapping around.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < ZONES; i++) begin
      idx = (int'(ptr) + i) % ZONES;
      if (!found && zif.zone_request[idx]) begin
        pick  = ZW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    run_end   = 1'b0;
    case (state)
      IDLE: begin
        if (!conflict && low_water_level && (|zif.zone_request)) state_nxt = SELECT;
      end
      SELECT: begin
        state_nxt = (|zif.zone_request) ? IRRIGATE : IDLE;
      end
      IRRIGATE: begin
        if (conflict) begin
          state_nxt = FAULT;
          run_end   = 1'b1;
        end else if (zif.abort || req_drop || done) begin
          state_nxt = IDLE;
          run_end   = 1'b1;
        end else if (!low_water_level) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (conflict) begin
          state_nxt = FAULT;
          run_end   = 1'b1;
        end else if (zif.abort || req_drop) begin
          state_nxt = IDLE;
          run_end   = 1'b1;
        end else if (low_water_level) begin
          state_nxt = IRRIGATE;
        end
      end
      FAULT: begin
        if (!conflict) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Valves follow the next state so they open on the first IRRIGATE cycle.
  assign zone_nxt    = start_run ? pick : zif.active_zone;
  assign mode_nxt    = start_run ? sprinkler_sel : sprinkler_mode;
  assign zone_onehot = {{(ZONES-1){1'b0}}, 1'b1} << zone_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      ptr                 <= '0;
      presc               <= '0;
      sprinkler_mode      <= 1'b0;
      zif.active_zone     <= '0;
      zif.sprinkler_valve <= '0;
      zif.dripper_valve   <= '0;
      zif.busy            <= 1'b0;
      water_supply_valve  <= 1'b0;
      alarm               <= 1'b0;
      conflicting_values  <= 1'b0;
    end else begin
      state              <= state_nxt;
      conflicting_values <= conflict;
      alarm              <= ~mid_water_level | conflict;
      water_supply_valve <= ~high_water_level & ~conflict;
      zif.busy           <= (state_nxt == SELECT) || (state_nxt == IRRIGATE) ||
                            (state_nxt == PAUSE);
      zif.active_zone    <= zone_nxt;
      sprinkler_mode     <= mode_nxt;
      if (run_end) ptr <= ptr_inc;
      if (state == SELECT) begin
        presc <= '0;
      end else if (state == IRRIGATE) begin
        presc <= tick ? '0 : presc + PW'(1);
      end
      if (state_nxt == IRRIGATE) begin
        zif.sprinkler_valve <= mode_nxt ? zone_onehot : '0;
        zif.dripper_valve   <= mode_nxt ? '0 : zone_onehot;
      end else begin
        zif.sprinkler_valve <= '0;
        zif.dripper_valve   <= '0;
      end
    end
  end

  bcd_countdown_timer u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (timer_clear),
    .load       (start_run),
    .load_value (sprinkler_sel ? SPRINKLER_TIME : DRIPPER_TIME),
    .tick       (tick),
    .value      (timer_value),
    .zero       (timer_zero),
    .last       (timer_last)
  );

  assign zif.timer_bcd = timer_value;

`ifdef CYCLE_COUNT_EN
  // Only runs that watered to completion or until the earth was wet are counted.
  logic count_run;
  assign count_run = run_end && (state_nxt == IDLE) && !zif.abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      runs_done <= 8'd0;
    end else if (count_run && (runs_done != 8'hFF)) begin
      runs_done <= runs_done + 8'd1;
    end
  end
`endif

endmodule
